// File: rtl/md5_candidate_gen.sv
// md5_candidate_gen: brute-force candidate enumerator feeding the MD5 pipeline core.
// Walks every string over CHARSET_SIZE symbols, shortest length first, one
// candidate per advancing cycle, presented right-aligned with a bit length.
module md5_candidate_gen #(
    parameter int         MAX_CHARS    = 8,
    parameter int         CHARSET_SIZE = 26,
    parameter logic [7:0] CHAR_BASE    = 8'h61,
    parameter int         COUNT_W      = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               advance,
    input  logic [5:0]         min_chars,
    input  logic [5:0]         max_chars,
    output logic [447:0]       message,
    output logic [63:0]        length,
    output logic               cand_valid,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [COUNT_W-1:0] cand_count
);

    localparam int DIG_W = (CHARSET_SIZE > 2) ? $clog2(CHARSET_SIZE) : 1;
    localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(CHARSET_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [5:0]         max_q, max_d;
    logic [5:0]         len_q, len_d;
    logic [DIG_W-1:0]   dig_q [MAX_CHARS];
    logic [DIG_W-1:0]   dig_d [MAX_CHARS];
    logic [447:0]       msg_q, msg_d;
    logic [63:0]        bitlen_q, bitlen_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    logic [447:0]       enc;
    logic [DIG_W-1:0]   dig_inc [MAX_CHARS];
    logic               wrap;
    logic               cfg_legal;

    assign cfg_legal = (min_chars != 6'd0) && (min_chars <= max_chars) &&
                       (int'(max_chars) <= MAX_CHARS);

    // Encode the current odometer into bytes and compute its incremented value;
    // wrap flags a carry out of the most significant active digit.
    always_comb begin
        enc     = '0;
        dig_inc = dig_q;
        wrap    = 1'b1;
        for (int k = 0; k < MAX_CHARS; k++) begin
            if (k < int'(len_q)) begin
                enc[8*k +: 8] = CHAR_BASE + 8'(dig_q[k]);
                if (wrap) begin
                    if (dig_q[k] == DIG_MAX) begin
                        dig_inc[k] = '0;
                    end else begin
                        dig_inc[k] = dig_q[k] + 1'b1;
                        wrap       = 1'b0;
                    end
                end
            end
        end
    end

    // Next-state and registered-output logic; stop outranks start and advance.
    always_comb begin
        state_d  = state_q;
        max_d    = max_q;
        len_d    = len_q;
        dig_d    = dig_q;
        msg_d    = msg_q;
        bitlen_d = bitlen_q;
        vld_d    = 1'b0;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (advance) begin
                    msg_d    = enc;
                    bitlen_d = {55'd0, len_q, 3'd0};
                    vld_d    = 1'b1;
                    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    if (!wrap) begin
                        dig_d = dig_inc;
                    end else if (len_q == max_q) begin
                        // Final candidate leaves on this edge together with DONE.
                        state_d = S_DONE;
                    end else begin
                        len_d = len_q + 6'd1;
                        for (int k = 0; k < MAX_CHARS; k++) dig_d[k] = '0;
                    end
                end
            end
            default: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    max_d = max_chars;
                    len_d = min_chars;
                    cnt_d = '0;
                    for (int k = 0; k < MAX_CHARS; k++) dig_d[k] = '0;
                    if (cfg_legal) begin
                        state_d = S_RUN;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
        endcase
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            max_q    <= '0;
            len_q    <= '0;
            msg_q    <= '0;
            bitlen_q <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            for (int k = 0; k < MAX_CHARS; k++) dig_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            max_q    <= max_d;
            len_q    <= len_d;
            msg_q    <= msg_d;
            bitlen_q <= bitlen_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
        end
    end

    assign message    = msg_q;
    assign length     = bitlen_q;
    assign cand_valid = vld_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign cfg_err    = err_q;
    assign cand_count = cnt_q;

endmodule

// File: tb/tb_md5_candidate_gen.sv
// Testbench for md5_candidate_gen: queue-based scoreboard fed by a string
// enumeration model, drained by an independent output monitor.
module tb_md5_candidate_gen;

    localparam int MAXC = 8;
    localparam int CS   = 26;
    localparam int CB   = 97;
    localparam int CW   = 48;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          advance = 1'b0;
    logic [5:0]    min_chars = '0;
    logic [5:0]    max_chars = '0;
    logic [447:0]  message;
    logic [63:0]   length;
    logic          cand_valid;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [CW-1:0] cand_count;

    md5_candidate_gen #(
        .MAX_CHARS(MAXC), .CHARSET_SIZE(CS), .CHAR_BASE(8'h61), .COUNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .advance(advance),
        .min_chars(min_chars), .max_chars(max_chars), .message(message),
        .length(length), .cand_valid(cand_valid), .busy(busy), .done(done),
        .cfg_err(cfg_err), .cand_count(cand_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [447:0] msg;
        longint       len;
        longint       cnt;
        bit           last;
    } exp_t;

    exp_t         exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           pops = 0;
    logic [447:0] last_msg = '0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [447:0] act, input logic [447:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: every string of length mn..mx in base-CS counting order,
    // last character in the low byte.
    task automatic push_expected(input int mn, input int mx);
        exp_t   e;
        longint total;
        longint v;
        longint idx;
        idx = 0;
        for (int L = mn; L <= mx; L++) begin
            total = 1;
            for (int i = 0; i < L; i++) total = total * CS;
            for (longint n = 0; n < total; n++) begin
                e.msg = '0;
                v = n;
                for (int p = 0; p < L; p++) begin
                    e.msg[8*p +: 8] = 8'(CB + (v % CS));
                    v = v / CS;
                end
                idx++;
                e.len  = 8 * L;
                e.cnt  = idx;
                e.last = (L == mx) && (n == total - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: pop one expected candidate per strobe; otherwise message must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_msg = '0;
        end else if (cand_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                pops++;
                chk_w("message", message, e.msg);
                chk("length", longint'(length), e.len);
                chk("cand_count", longint'(cand_count), e.cnt);
                chk("done_with_valid", longint'(done), longint'(e.last));
                chk("busy_with_valid", longint'(busy), longint'(!e.last));
            end
            last_msg = message;
        end else begin
            chk_w("message_hold", message, last_msg);
        end
    end

    task automatic run_cfg(input int mn, input int mx, input bit rnd, input int total);
        int p0;
        int cyc;
        p0 = pops;
        push_expected(mn, mx);
        @(negedge clk);
        min_chars = 6'(mn);
        max_chars = 6'(mx);
        start     = 1'b1;
        advance   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 20000) begin
            advance = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("run_timeout", longint'(cyc < 20000), 1);
        advance = 1'b0;
        @(negedge clk);
        chk("strobe_total", pops - p0, total);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_count", longint'(cand_count), total);
        chk("final_done", longint'(done), 1);
        chk("final_cfg_err", longint'(cfg_err), 0);
        chk("final_busy", longint'(busy), 0);
        chk("final_valid", longint'(cand_valid), 0);
        exp_q.delete();
    endtask

    task automatic illegal(input int mn, input int mx);
        int p0;
        p0 = pops;
        @(negedge clk);
        min_chars = 6'(mn);
        max_chars = 6'(mx);
        start     = 1'b1;
        advance   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("illegal_done", longint'(done), 1);
        chk("illegal_cfg_err", longint'(cfg_err), 1);
        chk("illegal_busy", longint'(busy), 0);
        chk("illegal_count", longint'(cand_count), 0);
        chk("illegal_strobes", pops - p0, 0);
        advance = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk_w({tag, "_message"}, message, '0);
        chk({tag, "_length"}, longint'(length), 0);
        chk({tag, "_valid"}, longint'(cand_valid), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_cfg_err"}, longint'(cfg_err), 0);
        chk({tag, "_count"}, longint'(cand_count), 0);
    endtask

    initial begin
        int p0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        run_cfg(1, 1, 1'b0, 26);
        run_cfg(1, 2, 1'b0, 702);
        run_cfg(2, 2, 1'b1, 676);

        // start and stop together in DONE: stop wins, back to IDLE
        @(negedge clk);
        min_chars = 6'd1; max_chars = 6'd1; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("collide_done", longint'(done), 0);
        chk("collide_busy", longint'(busy), 0);
        @(negedge clk);
        chk("collide_valid", longint'(cand_valid), 0);

        illegal(3, 2);
        illegal(0, 1);
        illegal(1, MAXC + 1);

        // abort after 10 candidates, advance kept high through the stop
        p0 = pops;
        push_expected(1, 3);
        @(negedge clk);
        min_chars = 6'd1; max_chars = 6'd3; start = 1'b1; advance = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_done", longint'(done), 0);
        chk("abort_valid", longint'(cand_valid), 0);
        chk("abort_count", longint'(cand_count), 10);
        chk("abort_strobes", pops - p0, 10);
        chk("abort_cfg_err", longint'(cfg_err), 0);
        advance = 1'b0;
        exp_q.delete();
        @(negedge clk);

        run_cfg(1, 1, 1'b0, 26);

        // asynchronous reset in the middle of a run
        push_expected(1, 2);
        @(negedge clk);
        min_chars = 6'd1; max_chars = 6'd2; start = 1'b1; advance = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        exp_q.delete();
        advance = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
